mips_dmem_bridge: RTL and testbench
===================================

MIPS_DMEM_BRIDGE -- requirements
Module: mips_dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max bus-wait cycles per transaction, legal range 1..255.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 SHALL have port clk  in  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port core_en  in  1  global run enable from the top level.
REQ-006 SHALL have port cpu_en  out  1  enable driven to the CPU core; low stalls the pipeline.
REQ-007 SHALL have port cpu_mem_read_en  in  1  CPU load request.
REQ-008 SHALL have port cpu_mem_write_en  in  4  CPU byte write enables; bit3 = byte addr 00, big-endian.
REQ-009 SHALL have port cpu_mem_addr  in  32  CPU byte address.
REQ-010 SHALL have port cpu_mem_write_data  in  32  CPU store data, already byte-replicated.
REQ-011 SHALL have port cpu_mem_read_data  out  32  load data, registered.
REQ-012 SHALL have port bus_req  out  1  bus transaction request.
REQ-013 SHALL have port bus_we  out  4  bus byte enables; 0000 = read.
REQ-014 SHALL have port bus_addr  out  32  word address, bits[1:0] = 00.
REQ-015 SHALL have port bus_wdata  out  32  bus write data.
REQ-016 SHALL have port bus_rdata  in  32  bus read data, valid with bus_ack.
REQ-017 SHALL have port bus_ack  in  1  one-cycle completion pulse.
REQ-018 SHALL have port err  out  1  sticky timeout flag.
REQ-019 SHALL have port err_addr  out  32  byte address of the first timed-out transaction.

Function
REQ-020 SHALL implement FSM states IDLE, RD_WAIT, RD_DONE, WR_BUSY.
REQ-021 Access accepted only in IDLE with core_en=1; read = cpu_mem_read_en=1; write = |cpu_mem_write_en.
REQ-022 Simultaneous read and write at acceptance SHALL be treated as write; read ignored.
REQ-023 IDLE + read: cpu_en=0 combinationally in that cycle; next state RD_WAIT; bus_req=1 from next cycle with bus_we=0000.
REQ-024 RD_WAIT: cpu_en=0; bus_req/bus_addr held stable until bus_ack; on bus_ack, latch bus_rdata into cpu_mem_read_data and drop bus_req next cycle; next state RD_DONE.
REQ-025 RD_DONE: cpu_en=core_en for exactly one cycle; the still-presented read SHALL NOT be reissued; next state IDLE.
REQ-026 cpu_mem_read_data SHALL hold its value until the next read completes.
REQ-027 IDLE + write: posted; capture addr/we/data into a one-entry write buffer; cpu_en stays high; next state WR_BUSY; bus_req=1 from next cycle.
REQ-028 WR_BUSY: cpu_en=0 while a new CPU read or write is presented; cpu_en=core_en otherwise; on bus_ack, free the buffer and go to IDLE, with cpu_en=0 in the ack cycle if an access is pending.
REQ-029 Bus ordering SHALL equal CPU program order; a read behind a buffered write waits for that write's ack.
REQ-030 Wait counter: 8 bits, cleared on entry to RD_WAIT/WR_BUSY, incremented each cycle bus_req=1 without bus_ack; never wraps.
REQ-031 When the counter reaches TIMEOUT with no ack: drop bus_req; set err; capture err_addr if err was 0; for a read, load ERR_DATA into cpu_mem_read_data and go to RD_DONE; for a write, discard it and go to IDLE.
REQ-032 An ack in the same cycle as the timeout SHALL win (normal completion, no error).
REQ-033 bus_ack while bus_req=0 SHALL be ignored.
REQ-034 core_en=0 SHALL force cpu_en=0 and block new acceptance, but SHALL NOT cancel an in-flight bus transaction.

Reset
REQ-035 On rst_n=0, asynchronously: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_mem_read_data=0, counter=0, buffer empty, err=0, err_addr=0.
REQ-036 cpu_en during reset SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon it with no further bus_req; err SHALL clear only on reset.

Verification
REQ-038 Read addr 0x104, ack 3 cycles later with 0x11223344: bus_addr=0x104, we=0000; cpu_en low 4 cycles then high 1; cpu_mem_read_data=0x11223344.
REQ-039 Store, we=0010, addr 0x22, then ALU ops: cpu_en never drops; bus_addr=0x20, bus_we=0010 held until ack.
REQ-040 Store then immediate load from same word: bus shows write, then read; load returns the written data from the bus model.
REQ-041 Read never acked, TIMEOUT=4: bus_req drops after 4 cycles; cpu_mem_read_data=0xDEADBEEF; err=1; err_addr=read address.
REQ-042 Ack coincident with timeout cycle: normal data returned, err stays 0.
REQ-043 rst_n low during RD_WAIT: all outputs reach REQ-035 values immediately; late ack ignored.

Source files
------------

// File: rtl/mips_dmem_bridge.sv
// rtl/mips_dmem_bridge.sv - MIPS data-memory bridge: stalls the core for loads, posts stores, times out hung bus cycles.
// Bus registers double as the one-entry posted-write buffer; state WR_BUSY means the buffer is occupied.
module mips_dmem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_en,
  output logic        cpu_en,
  input  logic        cpu_mem_read_en,
  input  logic [3:0]  cpu_mem_write_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_write_data,
  output logic [31:0] cpu_mem_read_data,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_BUSY} state_t;

  // Timeout fires on the cycle whose increment would make the count reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] req_addr;
  logic        wr_req;
  logic        rd_req;
  logic        cpu_access;
  logic        accept_wr;
  logic        accept_rd;
  logic        acked;
  logic        timed_out;

  // A simultaneous read and write is treated as the write alone.
  assign wr_req     = |cpu_mem_write_en;
  assign rd_req     = cpu_mem_read_en & ~wr_req;
  assign cpu_access = cpu_mem_read_en | wr_req;
  assign accept_wr  = (state == IDLE) & core_en & wr_req;
  assign accept_rd  = (state == IDLE) & core_en & rd_req;
  assign acked      = bus_req & bus_ack;
  assign timed_out  = bus_req & ~bus_ack & (wait_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_wr) begin
          state_nxt = WR_BUSY;
        end else if (accept_rd) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (acked || timed_out) begin
          state_nxt = RD_DONE;
        end
      end
      RD_DONE: state_nxt = IDLE;
      WR_BUSY: begin
        if (acked || timed_out) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A read presented behind a buffered write stalls until the write drains, keeping bus order.
  always_comb begin
    cpu_en = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    cpu_en = core_en & ~rd_req;
        RD_WAIT: cpu_en = 1'b0;
        RD_DONE: cpu_en = core_en;
        WR_BUSY: cpu_en = core_en & ~cpu_access;
        default: cpu_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req           <= 1'b0;
      bus_we            <= 4'b0000;
      bus_addr          <= 32'h0;
      bus_wdata         <= 32'h0;
      cpu_mem_read_data <= 32'h0;
      wait_cnt          <= 8'h0;
      req_addr          <= 32'h0;
      err               <= 1'b0;
      err_addr          <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_wr) begin
            bus_req   <= 1'b1;
            bus_we    <= cpu_mem_write_en;
            bus_addr  <= {cpu_mem_addr[31:2], 2'b00};
            bus_wdata <= cpu_mem_write_data;
            req_addr  <= cpu_mem_addr;
            wait_cnt  <= 8'h0;
          end else if (accept_rd) begin
            bus_req  <= 1'b1;
            bus_we   <= 4'b0000;
            bus_addr <= {cpu_mem_addr[31:2], 2'b00};
            req_addr <= cpu_mem_addr;
            wait_cnt <= 8'h0;
          end
        end
        RD_WAIT, WR_BUSY: begin
          if (acked) begin
            bus_req <= 1'b0;
            bus_we  <= 4'b0000;
            if (state == RD_WAIT) begin
              cpu_mem_read_data <= bus_rdata;
            end
          end else if (timed_out) begin
            bus_req <= 1'b0;
            bus_we  <= 4'b0000;
            err     <= 1'b1;
            if (!err) begin
              err_addr <= req_addr;
            end
            if (state == RD_WAIT) begin
              cpu_mem_read_data <= ERR_DATA;
            end
          end
          if (bus_req && !bus_ack && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// tb/tb_mips_dmem_bridge.sv - scoreboard bench for mips_dmem_bridge with a byte-lane bus memory model.
module tb_mips_dmem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_en = 1'b1;
  logic        cpu_en;
  logic        cpu_mem_read_en = 1'b0;
  logic [3:0]  cpu_mem_write_en = 4'b0000;
  logic [31:0] cpu_mem_addr = 32'h0;
  logic [31:0] cpu_mem_write_data = 32'h0;
  logic [31:0] cpu_mem_read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack;
  logic        err;
  logic [31:0] err_addr;

  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_delay = 0;
  int          checks = 0;
  int          failures = 0;

  assign bus_ack = model_ack | stray_ack;

  always #5 clk = ~clk;

  mips_dmem_bridge #(.TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .core_en(core_en), .cpu_en(cpu_en),
    .cpu_mem_read_en(cpu_mem_read_en), .cpu_mem_write_en(cpu_mem_write_en),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read_data(cpu_mem_read_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .err(err), .err_addr(err_addr)
  );

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } rd_exp_t;

  bus_exp_t bus_q[$];
  rd_exp_t  rd_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata, input int len);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [31:0] data, input int stall);
    rd_exp_t e;
    e.data = data; e.stall = stall;
    rd_q.push_back(e);
  endtask

  // Bus slave: acks the ack_delay-th cycle of a request (0 = never), merging byte lanes on writes.
  initial begin
    int wcnt;
    logic [31:0] word;
    wcnt = 0;
    mem[32'h104] = 32'h11223344;
    forever begin
      @(negedge clk);
      model_ack = 1'b0;
      if (bus_req === 1'b1) begin
        wcnt++;
        if (ack_delay != 0 && wcnt == ack_delay) begin
          model_ack = 1'b1;
          word = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
          if (bus_we == 4'b0000) begin
            bus_rdata = word;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (bus_we[i]) word[8*i +: 8] = bus_wdata[8*i +: 8];
            end
            mem[bus_addr] = word;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Bus monitor: checks each transaction's start, stability and request length.
  initial begin
    logic        prev_req;
    logic        have_cur;
    logic        stable;
    int          len;
    bus_exp_t    cur;
    logic [3:0]  cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    prev_req = 1'b0;
    have_cur = 1'b0;
    stable = 1'b1;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        len = 1; stable = 1'b1;
        cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata;
        if (bus_q.size() == 0) begin
          checks++; failures++; have_cur = 1'b0;
          $display("FAIL bus_unexpected: got addr %h we %b, expected no transaction", bus_addr, bus_we);
        end else begin
          cur = bus_q.pop_front();
          have_cur = 1'b1;
          chk32("bus_we", {28'h0, bus_we}, {28'h0, cur.we});
          chk32("bus_addr", bus_addr, cur.addr);
          if (cur.we != 4'b0000) chk32("bus_wdata", bus_wdata, cur.wdata);
        end
      end else if (bus_req && prev_req) begin
        len++;
        if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) stable = 1'b0;
      end else if (!bus_req && prev_req && have_cur) begin
        chk32("bus_stable", {31'h0, stable}, 32'd1);
        if (cur.len >= 0) chk32("bus_req_len", 32'(len), 32'(cur.len));
        have_cur = 1'b0;
      end
      prev_req = bus_req;
    end
  end

  // CPU monitor: load completion data and stall length; cpu_en must stay high when no access is presented.
  initial begin
    int      stall;
    rd_exp_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
      end else if (core_en && cpu_mem_read_en && cpu_mem_write_en == 4'b0000) begin
        if (!cpu_en) begin
          stall++;
        end else begin
          if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected: got data %h, expected no load completion", cpu_mem_read_data);
          end else begin
            e = rd_q.pop_front();
            chk32("cpu_mem_read_data", cpu_mem_read_data, e.data);
            if (e.stall >= 0) chk32("cpu_stall_cycles", 32'(stall), 32'(e.stall));
          end
          stall = 0;
        end
      end
      if (rst_n && core_en && !cpu_mem_read_en && cpu_mem_write_en == 4'b0000) begin
        chk32("cpu_en_no_access", {31'h0, cpu_en}, 32'd1);
      end
    end
  end

  task automatic cpu_op(input logic re, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    cpu_mem_read_en = re; cpu_mem_write_en = we; cpu_mem_addr = addr; cpu_mem_write_data = wdata;
    forever begin
      @(negedge clk);
      if (cpu_en) break;
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL cpu_op_timeout: got cpu_en low for %0d cycles, expected release", n);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_mem_read_en = 1'b0; cpu_mem_write_en = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk32("rst_cpu_en", {31'h0, cpu_en}, 32'd0);
    chk32("rst_bus_req", {31'h0, bus_req}, 32'd0);
    chk32("rst_bus_we", {28'h0, bus_we}, 32'd0);
    chk32("rst_bus_addr", bus_addr, 32'h0);
    chk32("rst_bus_wdata", bus_wdata, 32'h0);
    chk32("rst_rdata", cpu_mem_read_data, 32'h0);
    chk32("rst_err", {31'h0, err}, 32'd0);
    chk32("rst_err_addr", err_addr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    ack_delay = 3;
    exp_bus(4'b0000, 32'h104, 32'h0, 3);
    exp_rd(32'h11223344, 4);
    cpu_op(1'b1, 4'b0000, 32'h104, 32'h0);
    idle(2);

    exp_bus(4'b0010, 32'h20, 32'h5A5A5A5A, 3);
    cpu_op(1'b0, 4'b0010, 32'h22, 32'h5A5A5A5A);
    idle(6);

    ack_delay = 2;
    exp_bus(4'b1111, 32'h40, 32'hCAFEF00D, 2);
    exp_bus(4'b0000, 32'h40, 32'h0, 2);
    exp_rd(32'hCAFEF00D, 5);
    cpu_op(1'b0, 4'b1111, 32'h40, 32'hCAFEF00D);
    cpu_op(1'b1, 4'b0000, 32'h40, 32'h0);
    idle(2);

    ack_delay = 1;
    exp_bus(4'b1000, 32'h60, 32'h77000000, 1);
    cpu_op(1'b1, 4'b1000, 32'h60, 32'h77000000);
    idle(3);

    core_en = 1'b0;
    cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h104;
    repeat (3) @(negedge clk);
    #1;
    chk32("core_dis_cpu_en", {31'h0, cpu_en}, 32'd0);
    chk32("core_dis_bus_req", {31'h0, bus_req}, 32'd0);
    @(posedge clk); #1;
    core_en = 1'b1; cpu_mem_read_en = 1'b0;
    idle(2);

    ack_delay = TMO;
    exp_bus(4'b0000, 32'h104, 32'h0, 4);
    exp_rd(32'h11223344, 5);
    cpu_op(1'b1, 4'b0000, 32'h104, 32'h0);
    idle(1);
    chk32("ack_at_timeout_err", {31'h0, err}, 32'd0);

    ack_delay = 0;
    exp_bus(4'b0000, 32'h200, 32'h0, 4);
    exp_rd(32'hDEADBEEF, 5);
    cpu_op(1'b1, 4'b0000, 32'h200, 32'h0);
    idle(1);
    chk32("rd_timeout_err", {31'h0, err}, 32'd1);
    chk32("rd_timeout_err_addr", err_addr, 32'h200);

    exp_bus(4'b1111, 32'h300, 32'h12345678, 4);
    cpu_op(1'b0, 4'b1111, 32'h301, 32'h12345678);
    idle(6);
    chk32("wr_timeout_err", {31'h0, err}, 32'd1);
    chk32("wr_timeout_first_addr", err_addr, 32'h200);
    chk32("wr_timeout_rdata", cpu_mem_read_data, 32'hDEADBEEF);

    exp_bus(4'b0000, 32'h104, 32'h0, -1);
    cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h104;
    repeat (2) @(negedge clk);
    #1;
    chk32("pre_rst_bus_req", {31'h0, bus_req}, 32'd1);
    rst_n = 1'b0; cpu_mem_read_en = 1'b0;
    #1;
    chk32("mid_rst_bus_req", {31'h0, bus_req}, 32'd0);
    chk32("mid_rst_cpu_en", {31'h0, cpu_en}, 32'd0);
    chk32("mid_rst_bus_addr", bus_addr, 32'h0);
    chk32("mid_rst_rdata", cpu_mem_read_data, 32'h0);
    chk32("mid_rst_err", {31'h0, err}, 32'd0);
    chk32("mid_rst_err_addr", err_addr, 32'h0);
    stray_ack = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    stray_ack = 1'b0;
    idle(2);
    chk32("late_ack_rdata", cpu_mem_read_data, 32'h0);
    chk32("late_ack_bus_req", {31'h0, bus_req}, 32'd0);
    chk32("late_ack_err", {31'h0, err}, 32'd0);

    idle(4);
    chk32("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk32("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
